mac_vector_acc: RTL and testbench

MAC_VECTOR_ACC -- requirements
Module: mac_vector_acc

---
 rtl/mac_pkg.sv | 17 +
 rtl/mac_lane.sv | 87 ++++++++
 rtl/mac_vector_acc.sv | 107 ++++++++++
 tb/tb_mac_vector_acc.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// mac_pkg: shared definitions for the vector MAC accumulator.
// Holds the default lane widths and the frame FSM state encoding.
package mac_pkg;

    localparam int unsigned LEN_WEIGHT_DEF   = 8;
    localparam int unsigned LEN_DATA_IN_DEF  = 8;
    localparam int unsigned LEN_DATA_OUT_DEF = 18;
    localparam int unsigned NUM_LANE_DEF     = 4;
    localparam int unsigned LEN_CNT_DEF      = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAccum = 2'd1,
        StHold  = 2'd2
    } mac_state_e;

endpackage

// File: rtl/mac_lane.sv
// mac_lane: one multiply-accumulate lane with saturating accumulator.
// Ports:
//   CLK, ASYNC_RST_B   clock, asynchronous active-low reset
//   clr                synchronous abort, zeroes accumulator and flag
//   accept             a sample is taken this cycle
//   load               accepted sample is the first of a frame (restart from product)
//   data_in, weight    signed operands
//   acc_out            live accumulator value
//   sat_flag           saturation seen since the frame started (sticky)
module mac_lane import mac_pkg::*; #(
    parameter int unsigned LEN_WEIGHT   = LEN_WEIGHT_DEF,
    parameter int unsigned LEN_DATA_IN  = LEN_DATA_IN_DEF,
    parameter int unsigned LEN_DATA_OUT = LEN_DATA_OUT_DEF
) (
    input  logic                    CLK,
    input  logic                    ASYNC_RST_B,
    input  logic                    clr,
    input  logic                    accept,
    input  logic                    load,
    input  logic [LEN_DATA_IN-1:0]  data_in,
    input  logic [LEN_WEIGHT-1:0]   weight,
    output logic [LEN_DATA_OUT-1:0] acc_out,
    output logic                    sat_flag
);

    localparam int unsigned LEN_PROD = LEN_DATA_IN + LEN_WEIGHT;
    // One guard bit above the wider of accumulator and product, so the add cannot wrap.
    localparam int unsigned LEN_SUM  =
        ((LEN_DATA_OUT > LEN_PROD) ? LEN_DATA_OUT : LEN_PROD) + 1;

    localparam logic signed [LEN_SUM-1:0] SAT_MAX =
        {{(LEN_SUM - LEN_DATA_OUT + 1){1'b0}}, {(LEN_DATA_OUT - 1){1'b1}}};
    localparam logic signed [LEN_SUM-1:0] SAT_MIN =
        {{(LEN_SUM - LEN_DATA_OUT + 1){1'b1}}, {(LEN_DATA_OUT - 1){1'b0}}};

    logic signed [LEN_PROD-1:0]     data_ext;
    logic signed [LEN_PROD-1:0]     weight_ext;
    logic signed [LEN_PROD-1:0]     prod;
    logic signed [LEN_DATA_OUT-1:0] base;
    logic signed [LEN_SUM-1:0]      sum;
    logic        [LEN_DATA_OUT-1:0] acc_q, acc_d;
    logic                           sat_q, sat_d;

    // Operands widened to the product width; the low bits of the product are exact.
    assign data_ext   = {{LEN_WEIGHT{data_in[LEN_DATA_IN-1]}}, data_in};
    assign weight_ext = {{LEN_DATA_IN{weight[LEN_WEIGHT-1]}}, weight};
    assign prod       = data_ext * weight_ext;

    // First sample of a frame discards the old sum.
    assign base = load ? '0 : acc_q;
    assign sum  = {{(LEN_SUM - LEN_DATA_OUT){base[LEN_DATA_OUT-1]}}, base}
                + {{(LEN_SUM - LEN_PROD){prod[LEN_PROD-1]}}, prod};

    always_comb begin
        acc_d = acc_q;
        sat_d = sat_q;
        if (clr) begin
            acc_d = '0;
            sat_d = 1'b0;
        end else if (accept) begin
            sat_d = load ? 1'b0 : sat_q;
            if (sum > SAT_MAX) begin
                acc_d = {1'b0, {(LEN_DATA_OUT - 1){1'b1}}};
                sat_d = 1'b1;
            end else if (sum < SAT_MIN) begin
                acc_d = {1'b1, {(LEN_DATA_OUT - 1){1'b0}}};
                sat_d = 1'b1;
            end else begin
                acc_d = sum[LEN_DATA_OUT-1:0];
            end
        end
    end

    always_ff @(posedge CLK or negedge ASYNC_RST_B) begin
        if (!ASYNC_RST_B) begin
            acc_q <= '0;
            sat_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            sat_q <= sat_d;
        end
    end

    assign acc_out  = acc_q;
    assign sat_flag = sat_q;

endmodule

// File: rtl/mac_vector_acc.sv
// mac_vector_acc: NUM_LANE parallel saturating MACs accumulating frames of ACC_LEN samples.
// Ports:
//   CLK, ASYNC_RST_B        clock, asynchronous active-low reset
//   CLR                     synchronous abort of the current frame
//   ACC_LEN                 samples per frame, latched on the first sample (0 acts as 1)
//   IN_VALID/IN_READY       sample handshake for DATA_IN / WEIGHT_INPUT
//   DATA_IN, WEIGHT_INPUT   packed signed lane operands
//   OUT_VALID/OUT_READY     frame result handshake
//   DATA_OUT, SAT_FLAG      packed live accumulators and per-lane saturation flags
module mac_vector_acc import mac_pkg::*; #(
    parameter int unsigned LEN_WEIGHT   = LEN_WEIGHT_DEF,
    parameter int unsigned LEN_DATA_IN  = LEN_DATA_IN_DEF,
    parameter int unsigned LEN_DATA_OUT = LEN_DATA_OUT_DEF,
    parameter int unsigned NUM_LANE     = NUM_LANE_DEF,
    parameter int unsigned LEN_CNT      = LEN_CNT_DEF
) (
    input  logic                             CLK,
    input  logic                             ASYNC_RST_B,
    input  logic                             CLR,
    input  logic [LEN_CNT-1:0]               ACC_LEN,
    input  logic                             IN_VALID,
    output logic                             IN_READY,
    input  logic [NUM_LANE*LEN_DATA_IN-1:0]  DATA_IN,
    input  logic [NUM_LANE*LEN_WEIGHT-1:0]   WEIGHT_INPUT,
    output logic                             OUT_VALID,
    input  logic                             OUT_READY,
    output logic [NUM_LANE*LEN_DATA_OUT-1:0] DATA_OUT,
    output logic [NUM_LANE-1:0]              SAT_FLAG
);

    mac_state_e         state_q, state_d;
    logic [LEN_CNT-1:0] count_q, count_d;
    logic [LEN_CNT-1:0] len_q, len_d;
    logic               accept;
    logic               load;

    assign IN_READY  = (state_q != StHold);
    assign OUT_VALID = (state_q == StHold);
    assign accept    = IN_VALID & IN_READY & ~CLR;
    assign load      = accept & (state_q == StIdle);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        len_d   = len_q;
        if (CLR) begin
            state_d = StIdle;
            count_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (IN_VALID) begin
                        count_d = LEN_CNT'(1);
                        len_d   = (ACC_LEN == '0) ? LEN_CNT'(1) : ACC_LEN;
                        state_d = (ACC_LEN <= LEN_CNT'(1)) ? StHold : StAccum;
                    end
                end
                StAccum: begin
                    if (IN_VALID) begin
                        count_d = count_q + LEN_CNT'(1);
                        if (count_d == len_q) begin
                            state_d = StHold;
                        end
                    end
                end
                StHold: begin
                    // Leaving HOLD never accepts a sample in the same cycle.
                    if (OUT_READY) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge ASYNC_RST_B) begin
        if (!ASYNC_RST_B) begin
            state_q <= StIdle;
            count_q <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            len_q   <= len_d;
        end
    end

    for (genvar i = 0; i < NUM_LANE; i++) begin : g_lane
        mac_lane #(
            .LEN_WEIGHT   (LEN_WEIGHT),
            .LEN_DATA_IN  (LEN_DATA_IN),
            .LEN_DATA_OUT (LEN_DATA_OUT)
        ) u_lane (
            .CLK         (CLK),
            .ASYNC_RST_B (ASYNC_RST_B),
            .clr         (CLR),
            .accept      (accept),
            .load        (load),
            .data_in     (DATA_IN[i*LEN_DATA_IN +: LEN_DATA_IN]),
            .weight      (WEIGHT_INPUT[i*LEN_WEIGHT +: LEN_WEIGHT]),
            .acc_out     (DATA_OUT[i*LEN_DATA_OUT +: LEN_DATA_OUT]),
            .sat_flag    (SAT_FLAG[i])
        );
    end

endmodule

// File: tb/tb_mac_vector_acc.sv
module tb_mac_vector_acc;

    logic        CLK;
    logic        ASYNC_RST_B;
    logic        CLR;
    logic [7:0]  ACC_LEN;
    logic        IN_VALID;
    logic        IN_READY;
    logic [31:0] DATA_IN;
    logic [31:0] WEIGHT_INPUT;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [71:0] DATA_OUT;
    logic [3:0]  SAT_FLAG;

    int total;
    int bad;

    mac_vector_acc #(
        .LEN_WEIGHT   (8),
        .LEN_DATA_IN  (8),
        .LEN_DATA_OUT (18),
        .NUM_LANE     (4),
        .LEN_CNT      (8)
    ) dut (
        .CLK          (CLK),
        .ASYNC_RST_B  (ASYNC_RST_B),
        .CLR          (CLR),
        .ACC_LEN      (ACC_LEN),
        .IN_VALID     (IN_VALID),
        .IN_READY     (IN_READY),
        .DATA_IN      (DATA_IN),
        .WEIGHT_INPUT (WEIGHT_INPUT),
        .OUT_VALID    (OUT_VALID),
        .OUT_READY    (OUT_READY),
        .DATA_OUT     (DATA_OUT),
        .SAT_FLAG     (SAT_FLAG)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] d;
        logic [31:0] w;
        int          len;
        logic [71:0] exp;
        logic [3:0]  sat;
    } vec_t;

    vec_t vecs[4];

    function automatic logic [31:0] pk8(input int a0, input int a1, input int a2, input int a3);
        logic [31:0] r;
        r = {a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
        return r;
    endfunction

    function automatic logic [71:0] pk18(input int a0, input int a1, input int a2, input int a3);
        logic [71:0] r;
        r = {a3[17:0], a2[17:0], a1[17:0], a0[17:0]};
        return r;
    endfunction

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Feeds one full frame with constant operands, then checks and drains the result.
    task automatic run_frame(input logic [31:0] d, input logic [31:0] w, input int len,
                             input logic [71:0] exp, input logic [3:0] sat, input string nm);
        int   n;
        logic early;
        n     = (len == 0) ? 1 : len;
        early = 1'b0;
        ACC_LEN      = len[7:0];
        DATA_IN      = d;
        WEIGHT_INPUT = w;
        IN_VALID     = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0) early = 1'b1;
            tick();
            ACC_LEN = 8'd1;  // must not shorten the frame already in progress
        end
        IN_VALID = 1'b0;
        chk({nm, " early_valid"}, 72'(early), 72'(0));
        chk({nm, " out_valid"}, 72'(OUT_VALID), 72'(1));
        chk({nm, " data_out"}, DATA_OUT, exp);
        chk({nm, " sat_flag"}, 72'(SAT_FLAG), 72'(sat));
        OUT_READY = 1'b1;
        tick();
        OUT_READY = 1'b0;
        chk({nm, " drained"}, 72'(OUT_VALID), 72'(0));
    endtask

    initial begin
        logic flag;
        total        = 0;
        bad          = 0;
        CLK          = 1'b0;
        ASYNC_RST_B  = 1'b0;
        CLR          = 1'b0;
        ACC_LEN      = 8'd0;
        IN_VALID     = 1'b0;
        DATA_IN      = '0;
        WEIGHT_INPUT = '0;
        OUT_READY    = 1'b0;

        vecs[0] = '{d: pk8(-125, 2, -1, 0), w: pk8(3, 5, -1, 0), len: 4,
                    exp: pk18(-1500, 40, 4, 0), sat: 4'b0000};
        vecs[1] = '{d: pk8(0, 127, -128, 100), w: pk8(0, 127, 127, -50), len: 9,
                    exp: pk18(0, 131071, -131072, -45000), sat: 4'b0110};
        vecs[2] = '{d: pk8(10, 0, 0, 0), w: pk8(-2, 0, 0, 0), len: 0,
                    exp: pk18(-20, 0, 0, 0), sat: 4'b0000};
        vecs[3] = '{d: pk8(10, 0, 0, -128), w: pk8(-2, 0, 0, -128), len: 1,
                    exp: pk18(-20, 0, 0, 16384), sat: 4'b0000};

        #2;
        chk("rst data_out", DATA_OUT, 72'(0));
        chk("rst sat_flag", 72'(SAT_FLAG), 72'(0));
        #10;
        ASYNC_RST_B = 1'b1;
        tick();
        chk("rst out_valid", 72'(OUT_VALID), 72'(0));
        chk("rst in_ready", 72'(IN_READY), 72'(1));

        for (int k = 0; k < 4; k++) begin
            run_frame(vecs[k].d, vecs[k].w, vecs[k].len, vecs[k].exp, vecs[k].sat,
                      $sformatf("vec%0d", k));
        end

        // Backpressure in HOLD, then no bypass on the leaving edge.
        ACC_LEN      = 8'd2;
        DATA_IN      = pk8(1, 0, 0, 0);
        WEIGHT_INPUT = pk8(2, 0, 0, 0);
        IN_VALID     = 1'b1;
        tick();
        tick();
        ACC_LEN      = 8'd1;
        DATA_IN      = pk8(3, 0, 0, 0);
        WEIGHT_INPUT = pk8(1, 0, 0, 0);
        flag = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (IN_READY !== 1'b0 || OUT_VALID !== 1'b1 || DATA_OUT !== pk18(4, 0, 0, 0))
                flag = 1'b1;
            tick();
        end
        chk("bp hold stable", 72'(flag), 72'(0));
        OUT_READY = 1'b1;
        tick();
        OUT_READY = 1'b0;
        chk("bp leave valid", 72'(OUT_VALID), 72'(0));
        chk("bp no bypass", DATA_OUT, pk18(4, 0, 0, 0));
        tick();
        IN_VALID = 1'b0;
        chk("bp new valid", 72'(OUT_VALID), 72'(1));
        chk("bp new frame", DATA_OUT, pk18(3, 0, 0, 0));
        OUT_READY = 1'b1;
        tick();
        OUT_READY = 1'b0;

        // Asynchronous reset mid-frame.
        ACC_LEN      = 8'd4;
        DATA_IN      = pk8(5, 5, 5, 5);
        WEIGHT_INPUT = pk8(5, 5, 5, 5);
        IN_VALID     = 1'b1;
        tick();
        tick();
        IN_VALID = 1'b0;
        chk("pre-rst partial", DATA_OUT, pk18(50, 50, 50, 50));
        #2;
        ASYNC_RST_B = 1'b0;
        #1;
        chk("async rst data", DATA_OUT, 72'(0));
        chk("async rst valid", 72'(OUT_VALID), 72'(0));
        chk("async rst ready", 72'(IN_READY), 72'(1));
        #1;
        ASYNC_RST_B = 1'b1;
        tick();
        run_frame(pk8(1, 1, 1, 1), pk8(1, 1, 1, 1), 4, pk18(4, 4, 4, 4), 4'b0000, "post-rst");

        // CLR after 3 of 4 samples with IN_VALID still high.
        ACC_LEN      = 8'd4;
        DATA_IN      = pk8(2, 0, 0, 0);
        WEIGHT_INPUT = pk8(3, 0, 0, 0);
        IN_VALID     = 1'b1;
        tick();
        tick();
        tick();
        chk("clr partial", DATA_OUT, pk18(18, 0, 0, 0));
        CLR = 1'b1;
        tick();
        CLR      = 1'b0;
        IN_VALID = 1'b0;
        chk("clr data", DATA_OUT, 72'(0));
        chk("clr valid", 72'(OUT_VALID), 72'(0));
        flag = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (OUT_VALID !== 1'b0) flag = 1'b1;
        end
        chk("clr no result", 72'(flag), 72'(0));
        run_frame(vecs[0].d, vecs[0].w, vecs[0].len, vecs[0].exp, vecs[0].sat, "post-clr");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
